// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding data-memory port with request, grant and
// response handshakes. Loads are aligned and extended for writeback. Stores get
// byte strobes and lane-replicated data. Misaligned or reserved accesses
// raise a fault and are not issued.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [29:0] r_word;
    logic [1:0]  r_off;
    logic [2:0]  r_funct3;
    logic        r_store;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic [31:0] r_wb_data;

    logic        w_accept;
    logic        w_f3_ok;
    logic        w_misaligned;
    logic        w_legal;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata;
    logic [31:0] w_shift;
    logic [31:0] w_ext;

    assign wb_data = r_wb_data;

    // Decode the incoming instruction: legality, strobes and replicated store data.
    always_comb begin
        w_accept = (r_state == S_IDLE) & ex_valid & (is_load | is_store);
        case (funct3)
            3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
            3'b100, 3'b101:         w_f3_ok = is_load;
            default:                w_f3_ok = 1'b0;
        endcase
        w_misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                       ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
        w_legal = w_f3_ok & ~w_misaligned;
        case (funct3[1:0])
            2'b00: begin
                w_strb  = 4'b0001 << addr[1:0];
                w_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                w_strb  = 4'b0011 << addr[1:0];
                w_wdata = {2{store_data[15:0]}};
            end
            default: begin
                w_strb  = 4'b1111;
                w_wdata = store_data;
            end
        endcase
    end

    // Select the addressed byte/half of the returned word and extend it.
    // Halfword offsets are always 0 or 2, so one byte-granular shift serves both sizes.
    always_comb begin
        w_shift = mem_rdata >> {r_off, 3'b000};
        case (r_funct3)
            3'b000:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_ext = {24'd0, w_shift[7:0]};
            3'b101:  w_ext = {16'd0, w_shift[15:0]};
            default: w_ext = w_shift;
        endcase
    end

    // Next-state and output decode; memory request fields are driven only in REQ.
    always_comb begin
        w_next    = r_state;
        stall     = 1'b0;
        wb_valid  = 1'b0;
        fault     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wstrb = '0;
        mem_wdata = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_legal) begin
                        stall  = 1'b1;
                        w_next = S_REQ;
                    end else begin
                        fault = 1'b1;
                    end
                end
            end
            S_REQ: begin
                mem_req   = 1'b1;
                mem_we    = r_store;
                mem_addr  = {r_word, 2'b00};
                mem_wstrb = r_wstrb;
                mem_wdata = r_wdata;
                stall     = ~(r_store & mem_gnt);
                if (mem_gnt) begin
                    w_next = r_store ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (mem_rvalid) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                wb_valid = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register, request capture on legal accept, and load result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_word    <= '0;
            r_off     <= '0;
            r_funct3  <= '0;
            r_store   <= 1'b0;
            r_wstrb   <= '0;
            r_wdata   <= '0;
            r_wb_data <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept & w_legal) begin
                r_word   <= addr[31:2];
                r_off    <= addr[1:0];
                r_funct3 <= funct3;
                r_store  <= is_store;
                r_wstrb  <= is_store ? w_strb : 4'b0000;
                r_wdata  <= w_wdata;
            end
            if ((r_state == S_WAIT) & mem_rvalid) begin
                r_wb_data <= w_ext;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level reference model drives randomized
// and directed accesses and predicts every output on every cycle.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    load_store_unit dut (
        .clk        (clk),
        .reset      (reset),
        .ex_valid   (ex_valid),
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .fault      (fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    // Expected outputs for the current cycle, set by the driver from the model.
    bit          chk_on = 1'b0;
    bit          e_stall, e_wbv, e_fault, e_req, e_we;
    bit          e_memchk, e_wdchk;
    logic [31:0] e_addr, e_wdata, e_wb;
    logic [3:0]  e_strb;
    logic [31:0] m_wb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference rules.
    function automatic int unsigned ref_bytes(input logic [2:0] f3);
        return 32'd1 << f3[1:0];
    endfunction

    function automatic bit ref_legal(input bit ld, input logic [2:0] f3, input logic [31:0] a);
        bit ok;
        if (ld) ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        else    ok = (f3 <= 3'd2);
        return ok && ((a % ref_bytes(f3)) == 32'd0);
    endfunction

    function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] m;
        m = ((32'd1 << ref_bytes(f3)) - 32'd1) << a[1:0];
        return m[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
        if (ref_bytes(f3) == 1) return (sd % 32'h100) * 32'h01010101;
        if (ref_bytes(f3) == 2) return (sd % 32'h10000) * 32'h00010001;
        return sd;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        int unsigned nb;
        nb = ref_bytes(f3);
        v  = rd >> (8 * a[1:0]);
        if (nb < 4) begin
            v = v % (32'd1 << (8 * nb));
            if (!f3[2] && v >= (32'd1 << (8 * nb - 1))) v = v - (32'd1 << (8 * nb));
        end
        return v;
    endfunction

    // Single compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("stall",    32'(stall),    32'(e_stall));
            chk("wb_valid", 32'(wb_valid), 32'(e_wbv));
            chk("fault",    32'(fault),    32'(e_fault));
            chk("mem_req",  32'(mem_req),  32'(e_req));
            chk("wb_data",  wb_data,       e_wb);
            if (e_memchk) begin
                chk("mem_we",    32'(mem_we),    32'(e_we));
                chk("mem_addr",  mem_addr,       e_addr);
                chk("mem_wstrb", 32'(mem_wstrb), 32'(e_strb));
            end
            if (e_wdchk) chk("mem_wdata", mem_wdata, e_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        e_stall  = 1'b0;
        e_wbv    = 1'b0;
        e_fault  = 1'b0;
        e_req    = 1'b0;
        e_memchk = 1'b0;
        e_wdchk  = 1'b0;
        e_wb     = m_wb;
    endtask

    task automatic gap(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            tick();
            ex_valid   = 1'($urandom_range(0, 1));
            is_load    = 1'b0;
            is_store   = 1'b0;
            funct3     = 3'($urandom);
            addr       = $urandom;
            store_data = $urandom;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
            idle_exp();
        end
    endtask

    // One instruction from presentation to retirement; g/r are the cycles
    // grant and rvalid are withheld. Optional pinned literals for directed cases.
    task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input int unsigned g, input int unsigned r,
                         input logic [31:0] rd, input bit pin,
                         input logic [31:0] pv0, input logic [3:0] pv1);
        tick();
        ex_valid   = 1'b1;
        is_load    = ld;
        is_store   = st;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
        idle_exp();
        if (!(ld || st)) return;
        if (!ref_legal(ld, f3, a)) begin
            e_fault = 1'b1;
            if (pin) begin
                @(negedge clk);
                chk("pin_fault", 32'(fault), 32'd1);
            end
            return;
        end
        e_stall = 1'b1;
        for (int unsigned k = 0; k <= g; k++) begin
            tick();
            mem_gnt    = (k == g);
            mem_rvalid = (k < g) ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata  = $urandom;
            e_stall    = !(st && (k == g));
            e_req      = 1'b1;
            e_memchk   = 1'b1;
            e_wdchk    = st;
            e_we       = st;
            e_addr     = a & 32'hFFFF_FFFC;
            e_strb     = st ? ref_strb(f3, a) : 4'b0000;
            e_wdata    = ref_wdata(f3, sd);
            if (pin && st && k == 0) begin
                @(negedge clk);
                chk("pin_wdata", mem_wdata, pv0);
                chk("pin_wstrb", 32'(mem_wstrb), 32'(pv1));
            end
        end
        if (st) return;
        for (int unsigned k = 0; k <= r; k++) begin
            tick();
            mem_gnt    = 1'b0;
            mem_rvalid = (k == r);
            mem_rdata  = (k == r) ? rd : $urandom;
            idle_exp();
            e_stall    = 1'b1;
        end
        tick();
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
        m_wb       = ref_load(f3, a, rd);
        idle_exp();
        e_wbv      = 1'b1;
        if (pin) begin
            @(negedge clk);
            chk("pin_wb_data", wb_data, pv0);
        end
    endtask

    initial begin
        reset      = 1'b1;
        ex_valid   = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        funct3     = 3'd0;
        addr       = 32'd0;
        store_data = 32'd0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        m_wb       = 32'd0;
        idle_exp();
        e_we    = 1'b0;
        e_addr  = 32'd0;
        e_strb  = 4'd0;
        e_wdata = 32'd0;

        // Reset state
        tick();
        tick();
        e_memchk = 1'b1;
        e_wdchk  = 1'b1;
        chk_on   = 1'b1;
        tick();
        reset = 1'b0;
        idle_exp();
        gap(2);

        // Directed cases
        do_op(1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 4'h0);
        do_op(1, 0, 3'b000, 32'h203, 32'h0, 0, 0, 32'h80123456, 1, 32'hFFFFFF80, 4'h0);
        do_op(1, 0, 3'b100, 32'h203, 32'h0, 1, 2, 32'h80ABCDEF, 1, 32'h00000080, 4'h0);
        do_op(1, 0, 3'b001, 32'h202, 32'h0, 0, 0, 32'h80011234, 1, 32'hFFFF8001, 4'h0);
        do_op(0, 1, 3'b000, 32'h301, 32'h12345678, 0, 0, 32'h0, 1, 32'h78787878, 4'b0010);
        do_op(0, 1, 3'b001, 32'h302, 32'h12345678, 0, 0, 32'h0, 1, 32'h56785678, 4'b1100);
        do_op(0, 1, 3'b010, 32'h404, 32'hCAFEF00D, 3, 0, 32'h0, 1, 32'hCAFEF00D, 4'b1111);
        gap(1);
        do_op(1, 0, 3'b010, 32'h102, 32'h0, 0, 0, 32'h0, 1, 32'h0, 4'h0);
        do_op(0, 1, 3'b001, 32'h101, 32'h0, 0, 0, 32'h0, 1, 32'h0, 4'h0);
        do_op(1, 0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0, 1, 32'h0, 4'h0);
        do_op(0, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'h0, 0, 32'h0, 4'h0);
        gap(1);

        // Reset while waiting for read data; the late rvalid must be ignored
        tick();
        ex_valid = 1'b1; is_load = 1'b1; is_store = 1'b0;
        funct3 = 3'b010; addr = 32'h500; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        idle_exp();
        e_stall = 1'b1;
        tick();
        mem_gnt  = 1'b1;
        e_req    = 1'b1;
        e_memchk = 1'b1;
        e_we     = 1'b0;
        e_addr   = 32'h500;
        e_strb   = 4'b0000;
        tick();
        mem_gnt = 1'b0;
        reset   = 1'b1;
        idle_exp();
        e_stall = 1'b1;
        tick();
        reset      = 1'b0;
        ex_valid   = 1'b0;
        is_load    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        m_wb       = 32'd0;
        idle_exp();
        e_memchk = 1'b1;
        e_wdchk  = 1'b1;
        e_we     = 1'b0;
        e_addr   = 32'd0;
        e_strb   = 4'd0;
        e_wdata  = 32'd0;
        tick();
        mem_rvalid = 1'b0;
        idle_exp();
        gap(2);

        // Randomized traffic
        for (int unsigned it = 0; it < 300; it++) begin
            int unsigned sel;
            bit          ld, st;
            logic [2:0]  f3;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            ld  = (sel <= 4);
            st  = (sel >= 5) && (sel <= 8);
            if ($urandom_range(0, 4) == 0) begin
                f3 = 3'($urandom);
            end else if (ld) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 2));
            end
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(ref_bytes(f3) - 32'd1);
            do_op(ld, st, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom, 0, 32'h0, 4'h0);
            if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 2));
        end
        gap(2);
        tick();
        chk_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
